// File: rtl/imem_prog_if.sv
// imem_prog_if: fetch and program-load bundle for imem_prog.
//   addr        fetch word address              (master -> slave)
//   q           instruction at addr             (slave -> master)
//   load_valid  load word present this cycle    (master -> slave)
//   load_ready  memory accepts a load word      (slave -> master)
//   load_data   instruction word to store       (master -> slave)
//   load_last   word is the final program word  (master -> slave)
//   reload      restart clear+load while in RUN (master -> slave)
//   run         program complete, fetch valid   (slave -> master)
//   prog_len    number of words loaded          (slave -> master)
interface imem_prog_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 64
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] addr;
    logic [N-1:0]  q;
    logic          load_valid;
    logic          load_ready;
    logic [N-1:0]  load_data;
    logic          load_last;
    logic          reload;
    logic          run;
    logic [AW:0]   prog_len;

    modport master (
        output addr, load_valid, load_data, load_last, reload,
        input  q, load_ready, run, prog_len
    );

    modport slave (
        input  addr, load_valid, load_data, load_last, reload,
        output q, load_ready, run, prog_len
    );
endinterface

// File: rtl/imem_prog.sv
// imem_prog: programmable instruction memory for the single-cycle LEGv8 core.
// After reset the array is zero-cleared one word per edge, then a program is
// accepted over a valid/ready load port; once complete, run=1 and the core
// fetches combinationally. A reload in RUN restarts clear+load.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    imem_prog_if slave: fetch (addr/q), load port, reload, run, prog_len
module imem_prog #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 64
) (
    input logic        clk,
    input logic        reset,
    imem_prog_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   len_q, len_d;
    logic          we;
    logic [N-1:0]  wdata;

    logic [N-1:0]  mem [DEPTH];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        we      = 1'b0;
        wdata   = '0;
        unique case (state_q)
            StClear: begin
                we    = 1'b1;
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LastPtr) begin
                    ptr_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // load_ready is 1 throughout LOAD, so load_valid alone marks a transfer
                if (bus.load_valid) begin
                    we    = 1'b1;
                    wdata = bus.load_data;
                    ptr_d = ptr_q + 1'b1;
                    len_d = len_q + 1'b1;
                    // a full array ends the load regardless of load_last
                    if (bus.load_last || ptr_q == LastPtr) begin
                        ptr_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus.reload) begin
                    state_d = StClear;
                    ptr_d   = '0;
                    len_d   = '0;
                end
            end
            default: begin
                state_d = StClear;
                ptr_d   = '0;
                len_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StClear;
            ptr_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
        end
    end

    // Array has no reset of its own; CLEAR zeroes it after every reset/reload.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[ptr_q] <= wdata;
        end
    end

    // Moore outputs; fetch reads zero outside RUN so the core sees a harmless word.
    assign bus.load_ready = (state_q == StLoad);
    assign bus.run        = (state_q == StRun);
    assign bus.prog_len   = len_q;
    assign bus.q          = (state_q == StRun) ? mem[bus.addr] : '0;
endmodule

// File: tb/tb_imem_prog.sv
module tb_imem_prog;
    localparam int KQ   = 0;
    localparam int KRUN = 1;
    localparam int KRDY = 2;
    localparam int KLEN = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    logic reset;
    chk_t sb[$];
    int   total;
    int   bad;

    imem_prog_if #(.N(32), .DEPTH(64)) ifc ();

    imem_prog #(.N(32), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge, compare all expectations queued since the last one.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.kind)
                KQ:      act = ifc.q;
                KRUN:    act = {31'b0, ifc.run};
                KRDY:    act = {31'b0, ifc.load_ready};
                default: act = {25'b0, ifc.prog_len};
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_chk(input string n, input int k, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.kind = k;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic check_q(input string n, input int a, input logic [31:0] e);
        logic [31:0] av;
        av       = a;
        ifc.addr = av[5:0];
        push_chk(n, KQ, e);
        settle();
    endtask

    // One word over the load port; waits (bounded) for load_ready first.
    task automatic load_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        ifc.load_valid = 1'b1;
        ifc.load_data  = d;
        ifc.load_last  = last;
        while (!ifc.load_ready && n < 200) begin
            step();
            n++;
        end
        if (!ifc.load_ready) begin
            total++;
            bad++;
            $display("FAIL load_wait: got load_ready=0 want 1 within 200 cycles");
        end
        step();
        ifc.load_valid = 1'b0;
        ifc.load_last  = 1'b0;
    endtask

    // 64 CLEAR edges: load_ready low until the 64th, high after it.
    task automatic clear_wait(input string n);
        for (int i = 1; i <= 64; i++) begin
            step();
            push_chk(n, KRDY, (i == 64) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic pulse_reload();
        ifc.reload = 1'b1;
        step();
        ifc.reload = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        ifc.addr       = '0;
        ifc.load_valid = 1'b1;
        ifc.load_data  = 32'hdeadbeef;
        ifc.load_last  = 1'b1;
        ifc.reload     = 1'b0;

        // T1: reset, then 64 CLEAR edges with load_valid held high
        step();
        reset = 1'b0;
        push_chk("rst_ready", KRDY, 32'd0);
        push_chk("rst_run", KRUN, 32'd0);
        push_chk("rst_q", KQ, 32'd0);
        push_chk("rst_len", KLEN, 32'd0);
        for (int i = 1; i <= 64; i++) begin
            step();
            push_chk("t1_ready", KRDY, (i == 64) ? 32'd1 : 32'd0);
            push_chk("t1_run", KRUN, 32'd0);
            push_chk("t1_q", KQ, 32'd0);
            if (i == 64) ifc.load_valid = 1'b0;
        end
        push_chk("t1_len", KLEN, 32'd0);

        // T2: three-word program
        load_word(32'h8b1e03c5, 1'b0);
        load_word(32'h8b0400a5, 1'b0);
        push_chk("t2_run_early", KRUN, 32'd0);
        push_chk("t2_len2", KLEN, 32'd2);
        load_word(32'hcb020042, 1'b1);
        push_chk("t2_run", KRUN, 32'd1);
        push_chk("t2_ready", KRDY, 32'd0);
        push_chk("t2_len", KLEN, 32'd3);
        check_q("t2_a0", 0, 32'h8b1e03c5);
        check_q("t2_a1", 1, 32'h8b0400a5);
        check_q("t2_a2", 2, 32'hcb020042);
        check_q("t2_a3", 3, 32'h00000000);
        check_q("t2_a63", 63, 32'h00000000);

        // T3: full 64-word stream without load_last
        step();
        pulse_reload();
        clear_wait("t3_clear");
        for (int i = 0; i < 64; i++) begin
            load_word(32'(i), 1'b0);
            if (i == 62) push_chk("t3_run_63", KRUN, 32'd0);
        end
        push_chk("t3_run", KRUN, 32'd1);
        push_chk("t3_len", KLEN, 32'd64);
        check_q("t3_a63", 63, 32'h0000003f);
        check_q("t3_a10", 10, 32'h0000000a);
        ifc.load_valid = 1'b1;
        ifc.load_data  = 32'hffffffff;
        ifc.load_last  = 1'b1;
        step();
        step();
        step();
        ifc.load_valid = 1'b0;
        ifc.load_last  = 1'b0;
        push_chk("t3_extra_len", KLEN, 32'd64);
        push_chk("t3_extra_ready", KRDY, 32'd0);
        check_q("t3_extra_a0", 0, 32'h00000000);

        // T4: reload from RUN, single-word program
        step();
        ifc.addr = 6'd63;
        pulse_reload();
        push_chk("t4_run", KRUN, 32'd0);
        push_chk("t4_q", KQ, 32'd0);
        push_chk("t4_len0", KLEN, 32'd0);
        clear_wait("t4_clear");
        load_word(32'hb400001f, 1'b1);
        push_chk("t4_len", KLEN, 32'd1);
        check_q("t4_a0", 0, 32'hb400001f);
        check_q("t4_a1", 1, 32'h00000000);
        check_q("t4_a63", 63, 32'h00000000);

        // T5: reset in the middle of LOAD
        step();
        pulse_reload();
        clear_wait("t5_clear");
        load_word(32'h11111111, 1'b0);
        load_word(32'h22222222, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_chk("t5_ready", KRDY, 32'd0);
        push_chk("t5_run", KRUN, 32'd0);
        push_chk("t5_len", KLEN, 32'd0);
        clear_wait("t5_clear2");
        load_word(32'h33333333, 1'b1);
        push_chk("t5_len1", KLEN, 32'd1);
        check_q("t5_a0", 0, 32'h33333333);
        check_q("t5_a1", 1, 32'h00000000);

        // T6: toggling load_valid with reload held through LOAD
        step();
        pulse_reload();
        clear_wait("t6_clear");
        ifc.reload     = 1'b1;
        ifc.addr       = 6'd1;
        ifc.load_valid = 1'b1;
        ifc.load_data  = 32'haaaa0001;
        ifc.load_last  = 1'b0;
        step();
        ifc.load_valid = 1'b0;
        step();
        push_chk("t6_ready", KRDY, 32'd1);
        push_chk("t6_len1", KLEN, 32'd1);
        ifc.load_valid = 1'b1;
        ifc.load_data  = 32'haaaa0002;
        ifc.load_last  = 1'b1;
        step();
        ifc.load_valid = 1'b0;
        ifc.load_last  = 1'b0;
        push_chk("t6_run", KRUN, 32'd1);
        push_chk("t6_len", KLEN, 32'd2);
        push_chk("t6_a1", KQ, 32'haaaa0002);
        step();
        ifc.reload = 1'b0;
        push_chk("t6_reload_run", KRUN, 32'd0);
        push_chk("t6_reload_len", KLEN, 32'd0);
        settle();

        while (sb.size() > 0) settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
